// File: rtl/gf_pkg.sv
// gf_pkg: shared constants and types for the GF(2^8) arithmetic datapath.
//   GF_SIZE   field width in bits
//   GF_POLY   irreducible reduction polynomial (GF_SIZE+1 bits)
//   gf_elem_t one field element
//   state_t   divider sequencer states
package gf_pkg;

  localparam int                GF_SIZE = 8;
  localparam logic [GF_SIZE:0]  GF_POLY = 9'h11B;

  typedef logic [GF_SIZE-1:0] gf_elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP  = 2'd1,
    MUL  = 2'd2
  } state_t;

  // Bit idx of the inversion exponent 2^n-2: every bit is 1 except bit 0.
  function automatic logic inv_exp_bit(input logic [31:0] idx);
    return (idx != 32'd0);
  endfunction

endpackage

// File: rtl/gf_mul_comb.sv
// gf_mul_comb: combinational GF(2^Size) multiplier, o_p = i_a * i_b mod POLY.
//   i_a, i_b  operands (Size bits)
//   o_p       reduced product (Size bits)
// The multiplicand is doubled (xtime) and reduced at every step, so no
// intermediate ever grows beyond Size+1 bits.
module gf_mul_comb #(
  parameter int             Size = 8,
  parameter logic [Size:0]  POLY = 9'h11B
) (
  input  logic [Size-1:0] i_a,
  input  logic [Size-1:0] i_b,
  output logic [Size-1:0] o_p
);

  logic [Size-1:0] w_p;
  logic [Size-1:0] w_b;

  // Shift-and-XOR product with per-step reduction.
  always_comb begin
    w_p = '0;
    w_b = i_b;
    for (int i = 0; i < Size; i++) begin
      if (i_a[i]) begin
        w_p = w_p ^ w_b;
      end else begin
        w_p = w_p;
      end
      if (w_b[Size-1]) begin
        w_b = (w_b << 1) ^ POLY[Size-1:0];
      end else begin
        w_b = w_b << 1;
      end
    end
    o_p = w_p;
  end

endmodule

// File: rtl/gf_divider_seq.sv
// gf_divider_seq: sequential GF(2^Size) divider, quotient = dividend / divisor.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, accepted only while ready=1
//   dividend     numerator, sampled with an accepted start
//   divisor      denominator, sampled with an accepted start
//   ready        high in IDLE
//   done         one-cycle pulse, quotient/div_by_zero valid
//   quotient     result, held until the next done
//   div_by_zero  sampled divisor was zero, held until the next done
// The divisor is inverted as divisor^(2^Size-2) by square-and-multiply, one
// exponent bit per clock, then one final multiply by the dividend.
module gf_divider_seq
  import gf_pkg::*;
#(
  parameter int             Size = GF_SIZE,
  parameter logic [Size:0]  POLY = GF_POLY
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Size-1:0] dividend,
  input  logic [Size-1:0] divisor,
  output logic            ready,
  output logic            done,
  output logic [Size-1:0] quotient,
  output logic            div_by_zero
);

  localparam int              CNT_W    = (Size > 1) ? $clog2(Size) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Size - 1);
  localparam logic [Size-1:0]  ONE      = {{(Size-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [Size-1:0]  r_dvd,   w_dvd_nxt;
  logic [Size-1:0]  r_base,  w_base_nxt;
  logic [Size-1:0]  r_acc,   w_acc_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_done,  w_done_nxt;
  logic [Size-1:0]  r_quot,  w_quot_nxt;
  logic             r_dbz,   w_dbz_nxt;

  logic [Size-1:0]  w_m0_b;
  logic [Size-1:0]  w_m0_p;
  logic [Size-1:0]  w_m1_p;

  // The acc multiplier doubles as the final acc*dividend multiplier in MUL.
  assign w_m0_b = (r_state == MUL) ? r_dvd : r_base;

  gf_mul_comb #(.Size(Size), .POLY(POLY)) u_mul_acc (
    .i_a (r_acc),
    .i_b (w_m0_b),
    .o_p (w_m0_p)
  );

  gf_mul_comb #(.Size(Size), .POLY(POLY)) u_mul_sq (
    .i_a (r_base),
    .i_b (r_base),
    .o_p (w_m1_p)
  );

  // Next-state and next-datapath logic for the IDLE/EXP/MUL sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_dvd_nxt   = r_dvd;
    w_base_nxt  = r_base;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    w_quot_nxt  = r_quot;
    w_dbz_nxt   = r_dbz;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            w_dvd_nxt   = dividend;
            w_base_nxt  = divisor;
            w_acc_nxt   = ONE;
            w_cnt_nxt   = '0;
            w_state_nxt = EXP;
            w_ready_nxt = 1'b0;
          end else begin
            // Zero divisor short-circuits: answer in one edge, stay idle.
            w_done_nxt  = 1'b1;
            w_dbz_nxt   = 1'b1;
            w_quot_nxt  = '0;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXP: begin
        if (inv_exp_bit(32'(r_cnt))) begin
          w_acc_nxt = w_m0_p;
        end else begin
          w_acc_nxt = r_acc;
        end
        w_base_nxt = w_m1_p;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = MUL;
        end else begin
          w_state_nxt = EXP;
        end
      end
      MUL: begin
        w_quot_nxt  = w_m0_p;
        w_dbz_nxt   = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_base  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dvd   <= w_dvd_nxt;
      r_base  <= w_base_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_quot  <= w_quot_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_gf_divider_seq.sv
// tb_gf_divider_seq: self-checking bench for gf_divider_seq using a
// log/antilog table reference model of GF(2^8) mod 0x11B.
module tb_gf_divider_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       ready;
  logic       done;
  logic [7:0] quotient;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  int exp_t [0:254];
  int log_t [0:255];

  gf_divider_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tables built from generator 3: x*3 = xtime(x) ^ x.
  task automatic build_model();
    int e;
    int x2;
    e = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      x2 = (e << 1);
      if (x2 > 255) x2 = x2 ^ 'h11B;
      e = x2 ^ e;
    end
  endtask

  function automatic logic [7:0] model_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'h00 || a == 8'h00) return 8'h00;
    return 8'(exp_t[(log_t[a] - log_t[b] + 255) % 255]);
  endfunction

  // Issue one request at posedge+1; returns in the done cycle (posedge+1).
  // lat = edges after the accepting edge until done; rdy_bad counts busy
  // cycles where ready was not low.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit pulse_mid,
                        output logic [7:0] q, output logic dz, output int lat,
                        output int rdy_bad);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat      = 0;
    rdy_bad  = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (ready !== 1'b0) rdy_bad++;
      start    = (pulse_mid && lat == 3) ? 1'b1 : 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    q     = quotient;
    dz    = div_by_zero;
  endtask

  task automatic test_reset();
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || quotient !== 8'h00 || div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: ready=%b done=%b q=%h dz=%b, want 1 0 00 0",
               ready, done, quotient, div_by_zero);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q; logic dz; int lat; int rb;
    run_op(8'hC1, 8'h83, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h57 || dz !== 1'b0) begin
      n_errors++; $display("FAIL basic_q: got %h/%b want 57/0", q, dz);
    end
    n_checks++;
    if (lat !== 9) begin
      n_errors++; $display("FAIL basic_lat: got %0d want 9", lat);
    end
    n_checks++;
    if (rb !== 0 || ready !== 1'b1) begin
      n_errors++; $display("FAIL basic_ready: busy-high=%0d ready_at_done=%b want 0/1", rb, ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || quotient !== 8'h57) begin
      n_errors++; $display("FAIL basic_pulse: done=%b q=%h want 0/57", done, quotient);
    end
  endtask

  task automatic test_inverse();
    logic [7:0] q; logic dz; int lat; int rb;
    run_op(8'h01, 8'h53, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'hCA || lat !== 9) begin
      n_errors++; $display("FAIL inv_53: got %h lat %0d want CA lat 9", q, lat);
    end
    run_op(8'h01, 8'h01, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h01 || dz !== 1'b0) begin
      n_errors++; $display("FAIL inv_01: got %h/%b want 01/0", q, dz);
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q; logic dz; int lat; int rb;
    run_op(8'h5A, 8'h00, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h00 || dz !== 1'b1 || lat !== 0 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL div_zero: q=%h dz=%b lat=%0d ready=%b want 00 1 0 1", q, dz, lat, ready);
    end
    run_op(8'hC1, 8'h57, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h83 || dz !== 1'b0 || lat !== 9) begin
      n_errors++; $display("FAIL after_zero: q=%h dz=%b lat=%0d want 83 0 9", q, dz, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q; logic dz; int lat; int rb;
    run_op(8'hC1, 8'h83, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h57) begin
      n_errors++; $display("FAIL b2b_first: got %h want 57", q);
    end
    // Started in the done cycle; a mid-EXP start pulse must be ignored.
    run_op(8'hC1, 8'h57, 1'b1, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h83 || lat !== 9 || rb !== 0) begin
      n_errors++; $display("FAIL b2b_second: q=%h lat=%0d busy-high=%0d want 83 9 0", q, lat, rb);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_errors++; $display("FAIL b2b_ignored: done=%b ready=%b want 0 1", done, ready);
    end
  endtask

  task automatic test_abort();
    logic [7:0] q; logic dz; int lat; int rb;
    bit seen;
    start = 1'b1; dividend = 8'h12; divisor = 8'h34;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || done !== 1'b0 || quotient !== 8'h00 || div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_reset: ready=%b done=%b q=%h dz=%b want 1 0 00 0",
               ready, done, quotient, div_by_zero);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || ready !== 1'b1) begin
      n_errors++; $display("FAIL abort_nodone: done_seen=%b ready=%b want 0 1", seen, ready);
    end
    run_op(8'hC1, 8'h83, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== 8'h57 || lat !== 9) begin
      n_errors++; $display("FAIL abort_next: q=%h lat=%0d want 57 9", q, lat);
    end
  endtask

  task automatic check_one(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q; logic dz; int lat; int rb;
    logic [7:0] eq; logic edz; int elat;
    eq   = model_div(a, b);
    edz  = (b == 8'h00);
    elat = edz ? 0 : 9;
    run_op(a, b, 1'b0, q, dz, lat, rb);
    n_checks++;
    if (q !== eq || dz !== edz || lat !== elat || rb !== 0) begin
      n_errors++;
      $display("FAIL rand %h/%h: q=%h dz=%b lat=%0d busy-high=%0d want %h %b %0d 0",
               a, b, q, dz, lat, rb, eq, edz, elat);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    for (int d = 1; d < 256; d++) begin
      check_one(8'($urandom_range(0, 255)), 8'(d));
    end
    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      check_one(a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'h00;
    divisor  = 8'h00;
    build_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_inverse();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
